// File: rtl/dithered_pixel_tx.sv
// Frame readback: fetches binary pixels from SRAM, packs eight per byte and serves them as an SPI mode-0 slave.
// Optional build macro DITHER_TX_CHECKSUM_EN appends an XOR checksum byte after the last pixel byte.
module dithered_pixel_tx #(
    parameter int IMAGEX           = 64,
    parameter int IMAGEY           = 64,
    parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
    parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
    parameter int RGB_SIZE         = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        rd_en,
    output logic [IMAGE_ADDR_WIDTH-1:0] rd_addr,
    input  logic [RGB_SIZE-1:0]         rd_data,
    input  logic                        spi_sclk,
    input  logic                        spi_cs_n,
    output logic                        spi_miso,
    output logic                        tx_rdy,
    output logic                        busy,
    output logic                        tx_done
);

    localparam int NUM_BYTES = IMAGE_SIZE / 8;
`ifdef DITHER_TX_CHECKSUM_EN
    localparam int TOTAL_BYTES = NUM_BYTES + 1;
`else
    localparam int TOTAL_BYTES = NUM_BYTES;
`endif
    localparam int BW = $clog2(TOTAL_BYTES + 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, DONE} state_t;

    state_t                      state_q, state_d;
    logic [BW-1:0]               byte_idx, next_idx;
    logic [3:0]                  bit_cnt;
    logic [2:0]                  fetch_cnt;
    logic [7:0]                  hold_reg, shift_reg, byte_save, load_src;
    logic                        hold_valid, rd_en_d, cap_last, hold_ready;
    logic                        fetch_go, start_go, byte_done, more_pixels;
    logic [IMAGE_ADDR_WIDTH-1:0] fetch_base;
    logic [2:0]                  sclk_sr, cs_sr;
    logic                        sclk_rise, sclk_fall, cs_rise, cs_fall, cs_low;
    logic                        unused_bits;
`ifdef DITHER_TX_CHECKSUM_EN
    logic [7:0]                  csum;
`endif

    assign unused_bits = ^rd_data[RGB_SIZE-2:0];

    assign next_idx    = byte_idx + 1'b1;
    assign more_pixels = (next_idx < BW'(NUM_BYTES));
    assign cap_last    = rd_en_d & ~rd_en;
    assign hold_ready  = hold_valid | cap_last;
    assign byte_done   = (state_q == SHIFT) && (bit_cnt == 4'd8);

    // sr[1] is the synchronised level, sr[2] its previous value
    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign cs_fall   = ~cs_sr[1] & cs_sr[2];
    assign cs_rise   = cs_sr[1] & ~cs_sr[2];
    assign cs_low    = ~cs_sr[1];

    assign busy    = (state_q == FETCH) || (state_q == LOAD) || (state_q == SHIFT);
    assign tx_done = (state_q == DONE);

    always_comb begin
        load_src = hold_reg;
`ifdef DITHER_TX_CHECKSUM_EN
        if (byte_idx == BW'(NUM_BYTES)) load_src = csum;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        fetch_go   = 1'b0;
        start_go   = 1'b0;
        fetch_base = '0;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d  = FETCH;
                start_go = 1'b1;
                fetch_go = 1'b1;
            end
            FETCH: if (hold_ready) state_d = LOAD;
            LOAD: begin
                state_d = SHIFT;
                if (more_pixels) begin
                    fetch_go   = 1'b1;
                    fetch_base = IMAGE_ADDR_WIDTH'({next_idx, 3'b000});
                end
            end
            SHIFT: if (byte_done) begin
                if (next_idx == BW'(TOTAL_BYTES)) state_d = DONE;
`ifdef DITHER_TX_CHECKSUM_EN
                else if (next_idx == BW'(NUM_BYTES)) state_d = LOAD;
`endif
                else if (hold_ready) state_d = LOAD;
                else                 state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; later statements in this block take priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sr    <= '0;
            cs_sr      <= '1;
            rd_en      <= 1'b0;
            rd_en_d    <= 1'b0;
            rd_addr    <= '0;
            fetch_cnt  <= '0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            byte_idx   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            byte_save  <= '0;
            spi_miso   <= 1'b0;
            tx_rdy     <= 1'b0;
`ifdef DITHER_TX_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            sclk_sr <= {sclk_sr[1:0], spi_sclk};
            cs_sr   <= {cs_sr[1:0], spi_cs_n};
            rd_en_d <= rd_en;

            // Fetch sequencer: 8 reads, each pixel bit captured one clk after its read
            if (fetch_go) begin
                rd_en     <= 1'b1;
                rd_addr   <= fetch_base;
                fetch_cnt <= '0;
            end else if (rd_en) begin
                fetch_cnt <= fetch_cnt + 1'b1;
                if (fetch_cnt == 3'd7) rd_en   <= 1'b0;
                else                   rd_addr <= rd_addr + 1'b1;
            end
            if (rd_en_d)  hold_reg   <= {hold_reg[6:0], rd_data[RGB_SIZE-1]};
            if (cap_last) hold_valid <= 1'b1;

            if (byte_done) byte_idx <= next_idx;
            if (byte_done && state_d == DONE) tx_rdy <= 1'b0;
            if (start_go) begin
                byte_idx   <= '0;
                hold_valid <= 1'b0;
                bit_cnt    <= '0;
`ifdef DITHER_TX_CHECKSUM_EN
                csum       <= '0;
`endif
            end

            if (state_q == LOAD) begin
                shift_reg  <= load_src;
                byte_save  <= load_src;
                bit_cnt    <= '0;
                hold_valid <= 1'b0;
                tx_rdy     <= 1'b1;
                spi_miso   <= cs_low & load_src[7];
`ifdef DITHER_TX_CHECKSUM_EN
                if (byte_idx < BW'(NUM_BYTES)) csum <= csum ^ hold_reg;
`endif
            end else if (!tx_rdy) begin
                spi_miso <= 1'b0;
            end else if (cs_rise) begin
                // Aborted mid-byte: rewind so the whole byte is resent on the next CS
                spi_miso <= 1'b0;
                if (bit_cnt != 4'd0 && bit_cnt != 4'd8) begin
                    bit_cnt   <= '0;
                    shift_reg <= byte_save;
                end
            end else if (cs_fall) begin
                if (bit_cnt != 4'd8) begin
                    spi_miso <= shift_reg[7];
                    bit_cnt  <= '0;
                end
            end else if (cs_low) begin
                if (sclk_rise && bit_cnt < 4'd8) bit_cnt <= bit_cnt + 1'b1;
                if (sclk_fall && bit_cnt != 4'd0 && bit_cnt < 4'd8) begin
                    shift_reg <= {shift_reg[6:0], 1'b0};
                    spi_miso  <= shift_reg[6];
                end
            end else begin
                spi_miso <= 1'b0;
            end
        end
    end

endmodule
